// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage immediate extender with valid/ready handshake.
//
// Stage 1 captures the mode and the 24-bit instruction field; stage 2 forms
// the DATA_W-bit immediate and holds it on the output until it is consumed.
// A beat presented in the cycle after edge N is captured into S1 on edge N+1
// and is visible on the output after edge N+2.
//
// Modes: 00 data-processing immediate, 01 12-bit zero-extended offset,
//        10 sign-extended branch offset shifted left by BR_SHIFT,
//        11 illegal (extimm = 0, out_err = 1, beat still delivered).
//
// Build option: define ROTATE_EN to decode mode 00 as an 8-bit value rotated
// right by 2*instr[11:8]. Without it, mode 00 is a plain zero-extended
// instr[7:0], out_rot is constant 0 and no rotator is built.
//
// Handshake: on both sides a beat moves on a rising edge where valid and ready
// are both high. Ready never depends on the same side's valid; in_ready is a
// function of out_ready and the two stage valid bits only.

module imm_extend_pipe #(
  parameter int DATA_W   = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       instr,
  input  logic [1:0]        immsrc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] extimm,
  output logic              out_rot,
  output logic              out_err
);

  // Stage 1 contents
  logic        s1_valid;
  logic [1:0]  s1_immsrc;
  logic [23:0] s1_instr;

  // Stage ready terms; out_valid doubles as the stage 2 valid bit
  logic s1_ready;
  logic s2_ready;

  // Stage 2 next-state values
  logic [DATA_W-1:0] nxt_imm;
  logic              nxt_rot;
  logic              nxt_err;

  // Sign-extended branch offset before the shift
  logic [DATA_W-1:0] br_sext;

  assign s2_ready = !out_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;

  assign br_sext = {{(DATA_W-24){s1_instr[23]}}, s1_instr};

`ifdef ROTATE_EN
  localparam int RW = $clog2(DATA_W) + 1;

  // Rotation amount (2 * instr[11:8]) captured alongside the beat
  logic [4:0]        s1_rot;
  logic [DATA_W-1:0] imm8_ext;
  logic [DATA_W-1:0] rotated;
  logic [RW-1:0]     rot_comp;

  assign imm8_ext = {{(DATA_W-8){1'b0}}, s1_instr[7:0]};
  // A rotate of 0 makes rot_comp equal DATA_W, so the left part shifts out to 0
  assign rot_comp = RW'(DATA_W) - RW'(s1_rot);
  assign rotated  = (imm8_ext >> s1_rot) | (imm8_ext << rot_comp);

  // Capture the rotation amount whenever stage 1 loads a beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_rot <= '0;
    end else if (in_valid && s1_ready) begin
      s1_rot <= {instr[11:8], 1'b0};
    end
  end
`endif

  // Stage 1: load on accept, otherwise empty out when the beat moves to stage 2
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_immsrc <= 2'b00;
      s1_instr  <= '0;
    end else if (in_valid && s1_ready) begin
      s1_valid  <= 1'b1;
      s1_immsrc <= immsrc;
      s1_instr  <= instr;
    end else if (s2_ready) begin
      s1_valid  <= 1'b0;
    end
  end

  // Extension decode from stage 1 contents
  always_comb begin
    nxt_imm = '0;
    nxt_rot = 1'b0;
    nxt_err = 1'b0;
    case (s1_immsrc)
      2'b00: begin
`ifdef ROTATE_EN
        nxt_imm = rotated;
        nxt_rot = (s1_rot != 5'd0);
`else
        nxt_imm = {{(DATA_W-8){1'b0}}, s1_instr[7:0]};
`endif
      end
      2'b01: nxt_imm = {{(DATA_W-12){1'b0}}, s1_instr[11:0]};
      2'b10: nxt_imm = br_sext << BR_SHIFT;
      default: nxt_err = 1'b1;
    endcase
  end

  // Stage 2: load when stage 1 holds a beat and there is room; hold while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      extimm    <= '0;
      out_rot   <= 1'b0;
      out_err   <= 1'b0;
    end else if (s1_valid && s2_ready) begin
      out_valid <= 1'b1;
      extimm    <= nxt_imm;
      out_rot   <= nxt_rot;
      out_err   <= nxt_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed testbench for imm_extend_pipe. Inputs are driven 1 time unit after
// the rising edge, outputs are sampled on the falling edge. Expectations for
// mode 00 follow the ROTATE_EN build option.

module tb_imm_extend_pipe;

  localparam int DW = 32;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [23:0]   instr;
  logic [1:0]    immsrc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] extimm;
  logic          out_rot;
  logic          out_err;

  int n_pass;
  int n_total;

  imm_extend_pipe #(.DATA_W(DW), .BR_SHIFT(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .immsrc    (immsrc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .extimm    (extimm),
    .out_rot   (out_rot),
    .out_err   (out_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver
  task automatic drive(input logic v, input logic [1:0] m, input logic [23:0] ins);
    in_valid = v;
    immsrc   = m;
    instr    = ins;
  endtask

  // Reference model, packed as {err, rot, imm}; rotation done one bit at a time
  function automatic logic [DW+1:0] model(input logic [1:0] m, input logic [23:0] ins);
    logic [DW-1:0] v;
    logic r;
    logic e;
    v = '0;
    r = 1'b0;
    e = 1'b0;
    case (m)
      2'b00: begin
        v = {24'h0, ins[7:0]};
`ifdef ROTATE_EN
        for (int k = 0; k < 2 * int'(ins[11:8]); k++) v = {v[0], v[DW-1:1]};
        r = (ins[11:8] != 4'h0);
`endif
      end
      2'b01: v = {20'h0, ins[11:0]};
      2'b10: v = {{8{ins[23]}}, ins} << 2;
      default: e = 1'b1;
    endcase
    return {e, r, v};
  endfunction

  task automatic test_reset();
    reset_n   = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 24'h0);
    repeat (2) @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_total++; if (extimm !== 32'h0) $display("FAIL reset_extimm got=%h exp=0", extimm); else n_pass++;
    n_total++; if (out_rot !== 1'b0) $display("FAIL reset_out_rot got=%b exp=0", out_rot); else n_pass++;
    n_total++; if (out_err !== 1'b0) $display("FAIL reset_out_err got=%b exp=0", out_err); else n_pass++;
    reset_n = 1'b1;
  endtask

  // Single beats through an idle pipeline, checking latency and each mode
  task automatic test_modes();
    logic [1:0]  v_mode [10];
    logic [23:0] v_ins  [10];
    logic [31:0] v_imm  [10];
    logic        v_rot  [10];
    logic        v_err  [10];
    v_mode = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
    v_ins  = '{24'h0004FF, 24'h000A81, 24'h000023, 24'h000ABC, 24'hFFFFFF,
               24'hFFFFFE, 24'h000001, 24'h800000, 24'h7FFFFF, 24'h5A5A5A};
`ifdef ROTATE_EN
    v_imm  = '{32'hFF000000, 32'h00081000, 32'h00000023, 32'h00000ABC, 32'h00000FFF,
               32'hFFFFFFF8, 32'h00000004, 32'hFE000000, 32'h01FFFFFC, 32'h00000000};
    v_rot  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    v_imm  = '{32'h000000FF, 32'h00000081, 32'h00000023, 32'h00000ABC, 32'h00000FFF,
               32'hFFFFFFF8, 32'h00000004, 32'hFE000000, 32'h01FFFFFC, 32'h00000000};
    v_rot  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    v_err  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      drive(1'b1, v_mode[i], v_ins[i]);
      tick();
      drive(1'b0, 2'b00, 24'h0);
      @(negedge clk);
      n_total++; if (out_valid !== 1'b0) $display("FAIL mode_early_valid[%0d] got=%b exp=0", i, out_valid); else n_pass++;
      tick();
      @(negedge clk);
      n_total++; if (out_valid !== 1'b1) $display("FAIL mode_valid[%0d] got=%b exp=1", i, out_valid); else n_pass++;
      n_total++; if (extimm !== v_imm[i]) $display("FAIL mode_extimm[%0d] got=%h exp=%h", i, extimm, v_imm[i]); else n_pass++;
      n_total++; if (out_rot !== v_rot[i]) $display("FAIL mode_rot[%0d] got=%b exp=%b", i, out_rot, v_rot[i]); else n_pass++;
      n_total++; if (out_err !== v_err[i]) $display("FAIL mode_err[%0d] got=%b exp=%b", i, out_err, v_err[i]); else n_pass++;
    end
  endtask

  // Illegal beat between two legal neighbours, back to back
  task automatic test_illegal_order();
    out_ready = 1'b1;
    tick();
    drive(1'b1, 2'b01, 24'h000ABC);
    tick();
    drive(1'b1, 2'b11, 24'h123456);
    tick();
    drive(1'b1, 2'b10, 24'h000001);
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1 || extimm !== 32'h00000ABC || out_err !== 1'b0)
      $display("FAIL illegal_first got=%b/%h/%b exp=1/00000abc/0", out_valid, extimm, out_err); else n_pass++;
    tick();
    drive(1'b0, 2'b00, 24'h0);
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1 || extimm !== 32'h0 || out_err !== 1'b1 || out_rot !== 1'b0)
      $display("FAIL illegal_mid got=%b/%h/%b/%b exp=1/00000000/1/0", out_valid, extimm, out_err, out_rot); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1 || extimm !== 32'h00000004 || out_err !== 1'b0)
      $display("FAIL illegal_last got=%b/%h/%b exp=1/00000004/0", out_valid, extimm, out_err); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL illegal_drain got=%b exp=0", out_valid); else n_pass++;
  endtask

  // Three beats against a stalled consumer, then release
  task automatic test_backpressure();
    out_ready = 1'b0;
    tick();
    drive(1'b1, 2'b01, 24'h000111);
    tick();
    drive(1'b1, 2'b10, 24'h000002);
    tick();
    drive(1'b1, 2'b01, 24'h000333);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got=%b exp=0", c, in_ready); else n_pass++;
      n_total++; if (out_valid !== 1'b1 || extimm !== 32'h00000111)
        $display("FAIL bp_hold[%0d] got=%b/%h exp=1/00000111", c, out_valid, extimm); else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b1 || extimm !== 32'h00000111)
      $display("FAIL bp_out_a got=%b/%h exp=1/00000111", out_valid, extimm); else n_pass++;
    tick();
    drive(1'b0, 2'b00, 24'h0);
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1 || extimm !== 32'h00000008)
      $display("FAIL bp_out_b got=%b/%h exp=1/00000008", out_valid, extimm); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1 || extimm !== 32'h00000333)
      $display("FAIL bp_out_c got=%b/%h exp=1/00000333", out_valid, extimm); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", out_valid); else n_pass++;
  endtask

  // 100 random beats at full rate against the reference model
  task automatic test_back_to_back();
    logic [DW+1:0] exp_q[$];
    logic [DW+1:0] exp_v;
    int sent;
    int got;
    sent = 0;
    got  = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 110; c++) begin
      tick();
      if (sent < 100) drive(1'b1, 2'($urandom_range(0, 3)), 24'($urandom_range(0, 24'hFFFFFF)));
      else drive(1'b0, 2'b00, 24'h0);
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_total++; $display("FAIL stream_extra got=%h exp=none", extimm);
        end else begin
          exp_v = exp_q.pop_front();
          got++;
          n_total++; if ({out_err, out_rot, extimm} !== exp_v)
            $display("FAIL stream_beat[%0d] got=%b/%b/%h exp=%b/%b/%h", got, out_err, out_rot, extimm,
                     exp_v[DW+1], exp_v[DW], exp_v[DW-1:0]); else n_pass++;
        end
      end
      if (in_valid) begin
        n_total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d] got=%b exp=1", sent, in_ready); else n_pass++;
        if (in_ready) begin
          exp_q.push_back(model(immsrc, instr));
          sent++;
        end
      end
    end
    n_total++; if (got !== 100) $display("FAIL stream_count got=%0d exp=100", got); else n_pass++;
  endtask

  // Reset with two beats in flight, then a fresh beat
  task automatic test_reset_midstream();
    out_ready = 1'b0;
    tick();
    drive(1'b1, 2'b01, 24'h0000AA);
    tick();
    drive(1'b1, 2'b01, 24'h0000BB);
    tick();
    drive(1'b0, 2'b00, 24'h0);
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL rst_full got=%b/%b exp=1/0", out_valid, in_ready); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0 || extimm !== 32'h0)
      $display("FAIL rst_async got=%b/%h exp=0/00000000", out_valid, extimm); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else n_pass++;
    @(negedge clk);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    drive(1'b1, 2'b10, 24'h000001);
    tick();
    drive(1'b0, 2'b00, 24'h0);
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_new_early got=%b exp=0", out_valid); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1 || extimm !== 32'h00000004)
      $display("FAIL rst_new_beat got=%b/%h exp=1/00000004", out_valid, extimm); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      n_total++; if (out_valid !== 1'b0) $display("FAIL rst_ghost[%0d] got=%b/%h exp=0", c, out_valid, extimm); else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_modes();
    test_illegal_order();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
